// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and the queued write-back entry type for the writeback arbiter.
package writeback_arbiter_pkg;

    localparam int WB_DATA_W  = 32;
    localparam int REG_ADDR_W = 3;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Issue-slot result ports plus the register_file write port and hazard status.
interface writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int MASK_W = 1 << ADDR_W;

    logic              s0_valid;
    logic [ADDR_W-1:0] s0_addr;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [MASK_W-1:0] busy_mask;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
        input  s0_ready, s1_ready, wr_en, wr_addr, wr_data, busy_mask, occupancy
    );

    modport slave (
        input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
        output s0_ready, s1_ready, wr_en, wr_addr, wr_data, busy_mask, occupancy
    );

endinterface

// File: rtl/writeback_arbiter_wb_queue.sv
// Dual-push, single-pop circular queue with a per-entry valid vector.
module wb_queue
    import writeback_arbiter_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = WB_DEPTH,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push0_i,
    input  entry_t                 push0_entry_i,
    input  logic                   push1_i,
    input  entry_t                 push1_entry_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output entry_t [DEPTH-1:0]     entries_o,
    output logic   [DEPTH-1:0]     valid_o,
    output logic   [CNT_W-1:0]     count_o
);

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic   [DEPTH-1:0] valid_q, valid_d;
    logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic   [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic   [CNT_W-1:0] count_q, count_d;
    logic   [PTR_W-1:0] push1_idx;

    // Slot1 lands behind slot0 only when both enter in the same bundle.
    assign push1_idx = wr_ptr_q + PTR_W'(push0_i);

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push0_i) begin
            mem_d[wr_ptr_q]   = push0_entry_i;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (push1_i) begin
            mem_d[push1_idx]   = push1_entry_i;
            valid_d[push1_idx] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; the valid vector alone decides what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign count_o   = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Serializes two issue-slot results onto the single register_file write port.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_arbiter_if.slave bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int MASK_W = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               head;
    entry_t [DEPTH-1:0]   entries;
    logic   [DEPTH-1:0]   valid;
    logic   [CNT_W-1:0]   count;
    logic                 s0_ready, s1_ready, push0, push1, pop;
    logic   [MASK_W-1:0]  busy_mask;

    // Ready looks only at the registered count so valid never feeds ready.
    assign s0_ready = (count <= CNT_W'(DEPTH - 1));
    assign s1_ready = (count <= CNT_W'(DEPTH - 2));
    assign push0    = bus.s0_valid & s0_ready;
    assign push1    = bus.s1_valid & s1_ready;
    assign pop      = (count != '0);

    wb_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .push0_i       (push0),
        .push0_entry_i ('{addr: bus.s0_addr, data: bus.s0_data}),
        .push1_i       (push1),
        .push1_entry_i ('{addr: bus.s1_addr, data: bus.s1_data}),
        .pop_i         (pop),
        .head_o        (head),
        .entries_o     (entries),
        .valid_o       (valid),
        .count_o       (count)
    );

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                busy_mask[entries[i].addr] = 1'b1;
            end
        end
    end

    assign bus.s0_ready  = s0_ready;
    assign bus.s1_ready  = s1_ready;
    assign bus.wr_en     = pop;
    assign bus.wr_addr   = head.addr;
    assign bus.wr_data   = head.data;
    assign bus.busy_mask = busy_mask;
    assign bus.occupancy = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scoreboard bench for writeback_arbiter: reset, single, same-dest, fill, wrap, mid-reset.
module tb_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;
    exp_t sb[$];
    logic [DATA_W-1:0] rf [8];

    writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bus.s0_valid = v0;
        bus.s0_addr  = a0;
        bus.s0_data  = d0;
        bus.s1_valid = v1;
        bus.s1_addr  = a1;
        bus.s1_data  = d1;
    endtask

    function automatic logic [7:0] modelMask();
        logic [7:0] m = '0;
        foreach (sb[i]) m[sb[i].addr] = 1'b1;
        return m;
    endfunction

    // Check outputs against the queue model, then advance one clock with the model updated.
    task automatic step();
        int   n = sb.size();
        logic acc0, acc1;
        exp_t e;
        checkOutput("occupancy", 64'(bus.occupancy), 64'(n));
        checkOutput("wr_en", 64'(bus.wr_en), 64'(n != 0));
        checkOutput("s0_ready", 64'(bus.s0_ready), 64'(n <= DEPTH - 1));
        checkOutput("s1_ready", 64'(bus.s1_ready), 64'(n <= DEPTH - 2));
        checkOutput("busy_mask", 64'(bus.busy_mask), 64'(modelMask()));
        if (n != 0) begin
            checkOutput("wr_addr", 64'(bus.wr_addr), 64'(sb[0].addr));
            checkOutput("wr_data", 64'(bus.wr_data), 64'(sb[0].data));
        end
        if (bus.wr_en === 1'b1) rf[bus.wr_addr] = bus.wr_data;
        acc0 = bus.s0_valid && (n <= DEPTH - 1);
        acc1 = bus.s1_valid && (n <= DEPTH - 2);
        if (n != 0) e = sb.pop_front();
        if (acc0) sb.push_back('{bus.s0_addr, bus.s0_data});
        if (acc1) sb.push_back('{bus.s1_addr, bus.s1_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        foreach (rf[i]) rf[i] = '0;

        // Reset held two cycles with both slots presenting results.
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset_wr_en", 64'(bus.wr_en), 64'd0);
            checkOutput("reset_busy", 64'(bus.busy_mask), 64'd0);
            checkOutput("reset_occ", 64'(bus.occupancy), 64'd0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        checkOutput("reset_s0_ready", 64'(bus.s0_ready), 64'd1);
        checkOutput("reset_s1_ready", 64'(bus.s1_ready), 64'd1);
        step();

        // Single push from slot0.
        applyStimulus(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0);
        step();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        checkOutput("single_wr_en", 64'(bus.wr_en), 64'd1);
        checkOutput("single_wr_addr", 64'(bus.wr_addr), 64'd3);
        checkOutput("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
        checkOutput("single_busy", 64'(bus.busy_mask), 64'h08);
        step();
        checkOutput("single_done_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("single_done_busy", 64'(bus.busy_mask), 64'd0);
        step();

        // Same destination in one bundle: slot1 value must land last.
        applyStimulus(1'b1, 3'd5, 32'h1, 1'b1, 3'd5, 32'h2);
        step();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        checkOutput("dual_first_data", 64'(bus.wr_data), 64'h1);
        checkOutput("dual_busy_c1", 64'(bus.busy_mask), 64'h20);
        step();
        checkOutput("dual_second_data", 64'(bus.wr_data), 64'h2);
        checkOutput("dual_busy_c2", 64'(bus.busy_mask), 64'h20);
        step();
        checkOutput("dual_busy_clear", 64'(bus.busy_mask), 64'd0);
        checkOutput("dual_rf5", 64'(rf[5]), 64'h2);
        step();

        // Fill: both slots valid every cycle.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 3'(k), 32'h100 + 32'(2 * k), 1'b1, 3'(k + 4), 32'h101 + 32'(2 * k));
            if (k == 2) checkOutput("fill_occ_3", 64'(bus.occupancy), 64'd3);
            step();
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        repeat (5) step();

        // Wrap: ten back-to-back slot0 pushes.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 3'(i), 32'(i), 1'b0, 3'd0, 32'h0);
            step();
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        repeat (3) step();

        // Mid-operation reset with three entries queued.
        applyStimulus(1'b1, 3'd6, 32'hA0, 1'b1, 3'd7, 32'hA1);
        step();
        applyStimulus(1'b1, 3'd2, 32'hB0, 1'b1, 3'd4, 32'hB1);
        step();
        checkOutput("midrst_occ_before", 64'(bus.occupancy), 64'd3);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        checkOutput("midrst_wr_en", 64'(bus.wr_en), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy_mask), 64'd0);
        checkOutput("midrst_occ", 64'(bus.occupancy), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
